// File: rtl/dco_div_gen.sv
// ---------------------------------------------------------------------------
// dco_div_gen -- digitally controlled oscillator emulated by clock division.
//
// The system clock is divided by a ratio decoded from the tuning word
// `lambda`. The ratio of the running period only changes at a period
// boundary, so the output never glitches when the tuning word moves. When
// the enable drops, the current period is finished (drain) before the
// output parks low.
//
// Optional build macro: DCO_DITHER_EN
//   Defined   -> a FRAC_W-bit accumulator adds `frac` at every period start;
//                its carry-out stretches that period by one cycle, giving an
//                average ratio of ratio + frac/2^FRAC_W.
//   Undefined -> no accumulator, `frac` is ignored, integer ratio only.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   e            oscillator enable
//   lambda       tuning word (one-hot or unsigned binary, see ONEHOT)
//   frac         fractional tuning word (dither builds only)
//   clk_out      emulated DCO output, straight from a flop
//   period_tick  one-cycle pulse on the last cycle of each output period
//   cur_div      ratio of the period currently running
//   code_err     1 while the sampled one-hot tuning word is illegal
// ---------------------------------------------------------------------------
module dco_div_gen #(
    parameter int CTRL_W   = 10,
    parameter int ONEHOT   = 1,
    parameter int BASE_DIV = 2,
    parameter int STEP     = 1,
    parameter int DIV_W    = 16,
    parameter int FRAC_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              e,
    input  logic [CTRL_W-1:0] lambda,
    input  logic [FRAC_W-1:0] frac,
    output logic              clk_out,
    output logic              period_tick,
    output logic [DIV_W-1:0]  cur_div,
    output logic              code_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Tuning word decode (combinational part; registered below)
    // -----------------------------------------------------------------------
    logic [DIV_W-1:0] dec_ratio;
    logic             dec_legal;

    generate
        if (ONEHOT != 0) begin : g_onehot
            logic [DIV_W-1:0] masked [CTRL_W];

            // Each set bit contributes its own step ratio; with a legal code
            // exactly one term is non-zero, so OR-ing them selects it.
            for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_step
                assign masked[gi] = lambda[gi] ? DIV_W'(BASE_DIV + STEP * gi) : '0;
            end

            always_comb begin
                dec_ratio = '0;
                for (int i = 0; i < CTRL_W; i++) begin
                    dec_ratio = dec_ratio | masked[i];
                end
            end

            // Exactly one bit set: non-zero and clearing the lowest set bit
            // leaves nothing.
            assign dec_legal = (lambda != '0) && ((lambda & (lambda - 1'b1)) == '0);
        end else begin : g_binary
            assign dec_ratio = DIV_W'(BASE_DIV) + DIV_W'(STEP) * DIV_W'(lambda);
            assign dec_legal = 1'b1;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t           state_reg;
    state_t           state_next;
    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] cnt_next;
    logic [DIV_W-1:0] cur_div_reg;
    logic [DIV_W-1:0] cur_div_next;
    logic [DIV_W-1:0] ratio_reg;        // last legal decoded ratio
    logic             code_err_reg;
    logic             clk_out_reg;
    logic             clk_out_next;
    logic             tick_reg;
    logic             tick_next;
    logic             load;             // a new period starts on this edge
    logic [DIV_W-1:0] half_next;
    logic [DIV_W-1:0] period_ratio;     // ratio applied to a starting period

`ifdef DCO_DITHER_EN
    logic [FRAC_W-1:0] acc_reg;
    logic [FRAC_W-1:0] acc_next;
    logic [FRAC_W:0]   dither_sum;

    assign dither_sum   = {1'b0, acc_reg} + {1'b0, frac};
    // Carry-out of the accumulator lengthens the starting period by one.
    assign period_ratio = ratio_reg + DIV_W'(dither_sum[FRAC_W]);
`else
    logic unused_frac;

    assign unused_frac  = ^frac;
    assign period_ratio = ratio_reg;
`endif

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        cur_div_next = cur_div_reg;
        load         = 1'b0;
`ifdef DCO_DITHER_EN
        acc_next     = acc_reg;
`endif

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (e) begin
                    state_next = RUN;
                    load       = 1'b1;
                end
            end
            RUN, DRAIN: begin
                if (cnt_reg == cur_div_reg - 1'b1) begin
                    // Period boundary: the only point where the ratio moves.
                    cnt_next = '0;
                    if (e) begin
                        state_next = RUN;
                        load       = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next   = cnt_reg + 1'b1;
                    state_next = e ? RUN : DRAIN;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        if (load) begin
            cur_div_next = period_ratio;
`ifdef DCO_DITHER_EN
            acc_next     = dither_sum[FRAC_W-1:0];
`endif
        end
    end

    // Outputs are computed from the next count so that the registered
    // clk_out/period_tick line up with the count value they describe.
    assign half_next    = (cur_div_next >> 1) + DIV_W'(cur_div_next[0]);
    assign clk_out_next = (state_next != IDLE) && (cnt_next < half_next);
    assign tick_next    = (state_next != IDLE) && (cnt_next == cur_div_next - 1'b1);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            cur_div_reg  <= DIV_W'(BASE_DIV);
            ratio_reg    <= DIV_W'(BASE_DIV);
            code_err_reg <= 1'b0;
            clk_out_reg  <= 1'b0;
            tick_reg     <= 1'b0;
`ifdef DCO_DITHER_EN
            acc_reg      <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            cur_div_reg  <= cur_div_next;
            clk_out_reg  <= clk_out_next;
            tick_reg     <= tick_next;
            code_err_reg <= ~dec_legal;
            if (dec_legal) begin
                ratio_reg <= dec_ratio;
            end
`ifdef DCO_DITHER_EN
            acc_reg      <= acc_next;
`endif
        end
    end

    assign clk_out     = clk_out_reg;
    assign period_tick = tick_reg;
    assign cur_div     = cur_div_reg;
    assign code_err    = code_err_reg;

endmodule

// File: tb/tb_dco_div_gen.sv
// ---------------------------------------------------------------------------
// Testbench for dco_div_gen.
//
// A period-level reference model predicts clk_out, period_tick, cur_div and
// code_err for the one-hot instance; a compare process checks them on every
// falling edge. Directed literal checks pin the model (tick/high counts over
// whole-period windows, code_err, reset values) and cover a binary-coded
// instance.
// ---------------------------------------------------------------------------
module tb_dco_div_gen;

    localparam int CTRL_W   = 10;
    localparam int DIV_W    = 16;
    localparam int FRAC_W   = 4;
    localparam int BASE_DIV = 2;
    localparam int STEP     = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              e;
    logic [CTRL_W-1:0] lambda;
    logic [FRAC_W-1:0] frac;
    logic              clk_out;
    logic              period_tick;
    logic [DIV_W-1:0]  cur_div;
    logic              code_err;

    logic              e2;
    logic [CTRL_W-1:0] lambda2;
    logic [FRAC_W-1:0] frac2;
    logic              clk_out2;
    logic              period_tick2;
    logic [DIV_W-1:0]  cur_div2;
    logic              code_err2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dco_div_gen #(
        .CTRL_W(CTRL_W), .ONEHOT(1), .BASE_DIV(BASE_DIV), .STEP(STEP),
        .DIV_W(DIV_W), .FRAC_W(FRAC_W)
    ) dut (
        .clk(clk), .rst(rst), .e(e), .lambda(lambda), .frac(frac),
        .clk_out(clk_out), .period_tick(period_tick),
        .cur_div(cur_div), .code_err(code_err)
    );

    dco_div_gen #(
        .CTRL_W(CTRL_W), .ONEHOT(0), .BASE_DIV(BASE_DIV), .STEP(STEP),
        .DIV_W(DIV_W), .FRAC_W(FRAC_W)
    ) dut_bin (
        .clk(clk), .rst(rst), .e(e2), .lambda(lambda2), .frac(frac2),
        .clk_out(clk_out2), .period_tick(period_tick2),
        .cur_div(cur_div2), .code_err(code_err2)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model: each started period is expanded into a queue of
    // per-cycle (clk_out, tick) entries; a new period starts only once the
    // queue is empty and the enable is high.
    // -----------------------------------------------------------------------
    typedef struct {
        bit c;
        bit t;
    } ent_t;

    ent_t q[$];
    bit   m_valid = 0;
    bit   m_clk;
    bit   m_tick;
    int   m_div;
    int   m_held;
    bit   m_err;
    int   m_acc;

    initial begin
        ent_t ent;
        int   len;
        int   ones;
        int   idx;
        forever begin
            @(posedge clk);
            if (rst) begin
                q.delete();
                m_clk   = 0;
                m_tick  = 0;
                m_div   = BASE_DIV;
                m_held  = BASE_DIV;
                m_err   = 0;
                m_acc   = 0;
                m_valid = 1;
            end else begin
                if (q.size() == 0 && e) begin
                    len = m_held;
`ifdef DCO_DITHER_EN
                    m_acc = m_acc + int'(frac);
                    if (m_acc >= (1 << FRAC_W)) begin
                        len   = len + 1;
                        m_acc = m_acc - (1 << FRAC_W);
                    end
`endif
                    m_div = len;
                    for (int i = 0; i < len; i++) begin
                        ent.c = (i < (len + 1) / 2);
                        ent.t = (i == len - 1);
                        q.push_back(ent);
                    end
                end
                if (q.size() > 0) begin
                    ent    = q.pop_front();
                    m_clk  = ent.c;
                    m_tick = ent.t;
                end else begin
                    m_clk  = 0;
                    m_tick = 0;
                end
                // Tuning word takes effect for periods starting after this edge.
                ones = $countones(lambda);
                if (ones == 1) begin
                    idx = 0;
                    for (int i = 0; i < CTRL_W; i++) begin
                        if (lambda[i]) idx = i;
                    end
                    m_held = BASE_DIV + STEP * idx;
                    m_err  = 0;
                end else begin
                    m_err = 1;
                end
            end
        end
    end

    // Cycle-by-cycle compare against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("model_clk_out", int'(clk_out), int'(m_clk));
                chk("model_period_tick", int'(period_tick), int'(m_tick));
                chk("model_cur_div", int'(cur_div), m_div);
                chk("model_code_err", int'(code_err), int'(m_err));
            end
        end
    end

    // -----------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // -----------------------------------------------------------------------
    task automatic window(input int n, output int ticks, output int highs);
        ticks = 0;
        highs = 0;
        repeat (n) begin
            @(negedge clk);
            ticks += int'(period_tick);
            highs += int'(clk_out);
        end
    endtask

    task automatic wait_tick(input string name);
        bit found;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (period_tick) found = 1;
        end
        chk(name, int'(found), 1);
    endtask

    initial begin
        int ticks;
        int highs;
        int ticks2;
        int highs2;

        rst     = 1'b1;
        e       = 1'b0;
        lambda  = 10'b0000000001;
        frac    = '0;
        e2      = 1'b0;
        lambda2 = 10'd7;
        frac2   = '0;
        repeat (3) @(negedge clk);

        chk("reset_clk_out", int'(clk_out), 0);
        chk("reset_tick", int'(period_tick), 0);
        chk("reset_cur_div", int'(cur_div), 2);
        chk("reset_code_err", int'(code_err), 0);
        chk("reset_cur_div_bin", int'(cur_div2), 2);

        // Divide by 2.
        rst = 1'b0;
        e   = 1'b1;
        e2  = 1'b1;
        @(negedge clk);
        chk("start_clk_out_high", int'(clk_out), 1);
        window(10, ticks, highs);
        chk("div2_ticks", ticks, 5);
        chk("div2_highs", highs, 5);
        chk("div2_cur_div", int'(cur_div), 2);
        $display("div2: ticks=%0d highs=%0d cur_div=%0d", ticks, highs, cur_div);

        // Retune to step 3 mid-period: divide by 5, 3 high / 2 low.
        lambda = 10'b0000001000;
        repeat (12) @(negedge clk);
        chk("div5_cur_div", int'(cur_div), 5);
        window(20, ticks, highs);
        chk("div5_ticks", ticks, 4);
        chk("div5_highs", highs, 12);
        $display("div5: ticks=%0d highs=%0d cur_div=%0d", ticks, highs, cur_div);

        // Binary-coded instance, lambda=7 -> divide by 9 (5 high / 4 low).
        chk("bin_cur_div", int'(cur_div2), 9);
        ticks2 = 0;
        highs2 = 0;
        repeat (18) begin
            @(negedge clk);
            ticks2 += int'(period_tick2);
            highs2 += int'(clk_out2);
        end
        chk("bin_ticks", ticks2, 2);
        chk("bin_highs", highs2, 10);
        chk("bin_code_err", int'(code_err2), 0);
        $display("binary: ticks=%0d highs=%0d cur_div=%0d", ticks2, highs2, cur_div2);

        // Illegal one-hot codes: flag raised, ratio held.
        lambda = 10'b0000000110;
        @(negedge clk);
        chk("illegal_two_bits_err", int'(code_err), 1);
        chk("illegal_two_bits_div", int'(cur_div), 5);
        lambda = 10'b0000000000;
        @(negedge clk);
        chk("illegal_zero_err", int'(code_err), 1);
        window(20, ticks, highs);
        chk("illegal_ticks", ticks, 4);
        chk("illegal_highs", highs, 12);
        chk("illegal_cur_div", int'(cur_div), 5);
        lambda = 10'b0000001000;
        @(negedge clk);
        chk("legal_again_err", int'(code_err), 0);
        $display("illegal codes: ticks=%0d highs=%0d cur_div=%0d", ticks, highs, cur_div);

        // Drain: drop enable at cnt=1 of a divide-by-5 period.
        wait_tick("drain_align_tick");
        @(negedge clk);   // cnt=0
        @(negedge clk);   // cnt=1
        e = 1'b0;
        window(10, ticks, highs);
        chk("drain_ticks", ticks, 1);
        chk("drain_highs", highs, 1);
        chk("drain_idle_clk_out", int'(clk_out), 0);
        $display("drain: ticks=%0d highs=%0d", ticks, highs);

        // Re-enable: period starts on the next edge with clk_out high.
        e = 1'b1;
        @(negedge clk);
        chk("restart_clk_out", int'(clk_out), 1);
        chk("restart_tick", int'(period_tick), 0);

        // Reset in the middle of the high phase.
        wait_tick("rst_align_tick");
        @(negedge clk);
        chk("pre_rst_clk_out", int'(clk_out), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_clk_out", int'(clk_out), 0);
        chk("mid_rst_cur_div", int'(cur_div), 2);
        chk("mid_rst_tick", int'(period_tick), 0);
        $display("reset mid-period: clk_out=%0d cur_div=%0d", clk_out, cur_div);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Fractional word: dithered build alternates 2,3; integer build ignores it.
        rst    = 1'b1;
        e      = 1'b0;
        lambda = 10'b0000000001;
        frac   = 4'd8;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        e   = 1'b1;
        window(40, ticks, highs);
`ifdef DCO_DITHER_EN
        chk("dither_ticks", ticks, 16);
        chk("dither_highs", highs, 24);
`else
        chk("frac_ignored_ticks", ticks, 20);
        chk("frac_ignored_highs", highs, 20);
`endif
        $display("frac=8 over 40 cycles: ticks=%0d highs=%0d", ticks, highs);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
